// File: rtl/period_meter.sv
// Period and high-time meter for a slow asynchronous square wave, counted in Clk cycles.
// Results are registered and announced with a one-cycle Valid strobe.
module period_meter #(
  parameter int unsigned          CNT_W   = 24,
  parameter logic [CNT_W-1:0]     MAX_CNT = {CNT_W{1'b1}}
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Sig_In,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] High_Time,
  output logic             Valid,
  output logic             Timeout,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             hfrozen_q, hfrozen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             rise_c, fall_c;

  // Two-flop synchroniser plus a history flop; both edges see the same latency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Sig_In;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~s3_q;
  assign fall_c = ~s2_q & s3_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      hfrozen_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      hfrozen_q <= hfrozen_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state: arm on enable, measure rise-to-rise, abort when cnt saturates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    hfrozen_d = hfrozen_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!Enable) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      hcnt_d    = '0;
      hfrozen_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          if (rise_c) begin
            cnt_d     = CNT_W'(1);
            hcnt_d    = CNT_W'(1);
            hfrozen_d = 1'b0;
            state_d   = S_MEAS;
          end
        end
        S_MEAS: begin
          if (rise_c) begin
            period_d  = cnt_q;
            high_d    = hcnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_W'(1);
            hcnt_d    = CNT_W'(1);
            hfrozen_d = 1'b0;
          end else if (cnt_q == MAX_CNT) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            hcnt_d    = '0;
            hfrozen_d = 1'b0;
            state_d   = S_ARM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            // Freezing on the fall cycle itself keeps hcnt equal to t_fall - t_rise.
            if (fall_c) begin
              hfrozen_d = 1'b1;
            end else if (!hfrozen_q) begin
              hcnt_d = hcnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign Period    = period_q;
  assign High_Time = high_q;
  assign Valid     = valid_q;
  assign Timeout   = timeout_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: timestamp-based reference model, per-cycle
// comparison on the falling edge, directed scenarios plus randomized waveforms.
module tb_period_meter;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned MAXC  = 200;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sig;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  period_meter #(
    .CNT_W  (CNT_W),
    .MAX_CNT(CNT_W'(MAXC))
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .Enable   (en),
    .Sig_In   (sig),
    .Period   (period),
    .High_Time(high_time),
    .Valid    (valid),
    .Timeout  (timeout),
    .Busy     (busy)
  );

  // Reference model: works on edge timestamps of the input as seen at each Clk edge.
  int edge_n, t_rise, t_fall, mode;  // mode 0 idle, 1 armed, 2 measuring
  bit have_fall;
  bit hist[$];
  int exp_period, exp_high;
  bit exp_valid, exp_timeout, exp_busy;

  function automatic bit past(int k);
    if (hist.size() > k) return hist[hist.size() - 1 - k];
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit r, f;
    if (rst) begin
      edge_n = 0; t_rise = 0; t_fall = 0; mode = 0; have_fall = 0;
      hist.delete();
      exp_period = 0; exp_high = 0;
      exp_valid = 0; exp_timeout = 0; exp_busy = 0;
    end else begin
      edge_n++;
      hist.push_back(sig);
      if (hist.size() > 8) void'(hist.pop_front());
      r = past(2) & ~past(3);
      f = ~past(2) & past(3);
      exp_valid = 0;
      if (!en) mode = 0;
      else if (mode == 0) mode = 1;
      else if (mode == 1) begin
        if (r) begin mode = 2; t_rise = edge_n; have_fall = 0; end
      end else begin
        if (r) begin
          exp_period  = edge_n - t_rise;
          exp_high    = have_fall ? (t_fall - t_rise) : (edge_n - t_rise);
          exp_valid   = 1;
          exp_timeout = 0;
          t_rise      = edge_n;
          have_fall   = 0;
        end else if (edge_n - t_rise == int'(MAXC)) begin
          exp_timeout = 1;
          mode        = 1;
        end else if (f && !have_fall) begin
          have_fall = 1;
          t_fall    = edge_n;
        end
      end
      exp_busy = (mode != 0);
    end
  end

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("period",    int'(period),    exp_period);
      cmp("high_time", int'(high_time), exp_high);
      cmp("valid",     int'(valid),     int'(exp_valid));
      cmp("timeout",   int'(timeout),   int'(exp_timeout));
      cmp("busy",      int'(busy),      int'(exp_busy));
    end
  end

  // Advance n rising edges and land 2 time units after the last one.
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic square(int per, int hi, int n);
    repeat (n) begin
      sig = 1'b1; tick(hi);
      sig = 1'b0; tick(per - hi);
    end
  endtask

  initial begin
    int hi, lo;
    rst = 1'b1; en = 1'b0; sig = 1'b0;
    #1 chk_en = 1'b1;

    // Reset held with the input toggling.
    for (int i = 0; i < 8; i++) begin
      sig = i[0];
      tick(1);
    end
    cmp("rst_period",  int'(period), 0);
    cmp("rst_high",    int'(high_time), 0);
    cmp("rst_busy",    int'(busy), 0);
    cmp("rst_timeout", int'(timeout), 0);
    sig = 1'b0;
    rst = 1'b0;
    tick(3);

    // 100-cycle period, 30 high.
    en = 1'b1;
    square(100, 30, 5);
    cmp("sq_period", int'(period), 100);
    cmp("sq_high",   int'(high_time), 30);

    // Input is bit 3 of a free-running counter.
    for (int k = 0; k < 256; k++) begin
      sig = k[3];
      tick(1);
    end
    cmp("div_period", int'(period), 16);
    cmp("div_high",   int'(high_time), 8);

    // One rise then held high: timeout 200 cycles after the detected rise.
    sig = 1'b0; tick(10);
    sig = 1'b1; tick(202);
    cmp("to_before", int'(timeout), 0);
    tick(1);
    cmp("to_set",    int'(timeout), 1);
    cmp("to_busy",   int'(busy), 1);
    cmp("to_valid",  int'(valid), 0);
    tick(20);
    sig = 1'b0; tick(20);
    sig = 1'b1; tick(30);
    sig = 1'b0; tick(20);
    sig = 1'b1; tick(3);
    cmp("rec_valid",   int'(valid), 1);
    cmp("rec_timeout", int'(timeout), 0);
    cmp("rec_period",  int'(period), 50);
    cmp("rec_high",    int'(high_time), 30);
    sig = 1'b0; tick(20);

    // Enable dropped for a single cycle mid-period.
    square(100, 30, 3);
    sig = 1'b1; tick(15);
    en = 1'b0; tick(1);
    cmp("dis_busy",   int'(busy), 0);
    cmp("dis_period", int'(period), 100);
    en = 1'b1; tick(15);
    sig = 1'b0; tick(70);
    square(100, 30, 3);

    // Asynchronous reset between clock edges mid-measurement.
    sig = 1'b1; tick(10);
    rst = 1'b1;
    #1;
    cmp("arst_period", int'(period), 0);
    cmp("arst_high",   int'(high_time), 0);
    cmp("arst_busy",   int'(busy), 0);
    tick(2);
    rst = 1'b0; sig = 1'b0;
    tick(2);
    square(100, 30, 4);
    cmp("post_period", int'(period), 100);
    cmp("post_high",   int'(high_time), 30);

    // Randomized waveforms with occasional enable drops and stalls.
    for (int s = 0; s < 60; s++) begin
      hi = int'($urandom_range(1, 60));
      lo = int'($urandom_range(1, 60));
      if ($urandom_range(0, 14) == 0) hi = 250;
      if ($urandom_range(0, 14) == 0) lo = 250;
      sig = 1'b1; tick(hi);
      if ($urandom_range(0, 9) == 0) begin
        en = 1'b0; tick(int'($urandom_range(1, 3))); en = 1'b1;
      end
      sig = 1'b0; tick(lo);
    end
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
